crc_frame_tx: RTL and testbench

Serial CRC-8 frame transmitter for the network controller datapath. It accepts a parallel data word through a ready/start handshake and shifts it out one bit per bit-slot tick, MSB first. It then appends the 8-bit CRC computed over the transmitted data bits. The bit-slot tick is the single-cycle `Rollover` pulse of the upstream modulo-k baud counter, which sets the line bit rate.

---
 rtl/crc_frame_tx.sv | 147 ++++++++++++++
 tb/tb_crc_frame_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_tx.sv
// Serial CRC-8 frame transmitter: payload MSB first, then CRC-8 over the payload bits.
// Optional 8'h7E preamble ahead of the payload when CRC_TX_PREAMBLE_EN is defined.
module crc_frame_tx #(
  parameter int         DATA_W = 16,
  parameter logic [7:0] POLY   = 8'h07,
  parameter logic [7:0] INIT   = 8'h00
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Tick,
  input  logic              Start,
  input  logic [DATA_W-1:0] Data,
  output logic              Ready,
  output logic              TxBit,
  output logic              TxValid,
  output logic              Done
);

  localparam int MAXW = (DATA_W > 8) ? DATA_W : 8;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(7);

`ifdef CRC_TX_PREAMBLE_EN
  localparam logic [7:0] PREAMBLE = 8'h7E;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_CRC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;
`endif

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n, shifted;
  logic [7:0]        crc, crc_n, crc_upd;
  logic [CW-1:0]     cnt, cnt_n, cnt_dec;
  logic              ready, ready_n;
  logic              tx_bit, bit_n;
  logic              tx_valid, valid_n;
  logic              done, done_n;
  logic              fb;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      shreg    <= '0;
      crc      <= INIT;
      cnt      <= '0;
      ready    <= 1'b1;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      crc      <= crc_n;
      cnt      <= cnt_n;
      ready    <= ready_n;
      tx_bit   <= bit_n;
      tx_valid <= valid_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    crc_n   = crc;
    cnt_n   = cnt;
    ready_n = ready;
    bit_n   = tx_bit;
    valid_n = tx_valid;
    done_n  = 1'b0;
    // The bit being consumed by this Tick is the one currently on the line.
    fb      = tx_bit ^ crc[7];
    crc_upd = {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    shifted = shreg << 1;
    cnt_dec = cnt - 1'b1;
    case (state)
      S_IDLE: begin
        if (Start) begin
          shreg_n = Data;
          crc_n   = INIT;
          ready_n = 1'b0;
          valid_n = 1'b1;
`ifdef CRC_TX_PREAMBLE_EN
          state_n = S_PRE;
          cnt_n   = LAST_BYTE;
          bit_n   = PREAMBLE[7];
`else
          state_n = S_DATA;
          cnt_n   = LAST_DATA;
          bit_n   = Data[DATA_W-1];
`endif
        end
      end
`ifdef CRC_TX_PREAMBLE_EN
      S_PRE: begin
        if (Tick) begin
          if (cnt == '0) begin
            state_n = S_DATA;
            cnt_n   = LAST_DATA;
            bit_n   = shreg[DATA_W-1];
          end else begin
            cnt_n = cnt_dec;
            bit_n = PREAMBLE[cnt_dec[2:0]];
          end
        end
      end
`endif
      S_DATA: begin
        if (Tick) begin
          crc_n = crc_upd;
          if (cnt == '0) begin
            state_n = S_CRC;
            cnt_n   = LAST_BYTE;
            bit_n   = crc_upd[7];
          end else begin
            cnt_n   = cnt_dec;
            shreg_n = shifted;
            bit_n   = shifted[DATA_W-1];
          end
        end
      end
      S_CRC: begin
        // CRC bits are selected by index so the register keeps the final checksum.
        if (Tick) begin
          if (cnt == '0) begin
            state_n = S_IDLE;
            valid_n = 1'b0;
            bit_n   = 1'b0;
            done_n  = 1'b1;
            ready_n = 1'b1;
          end else begin
            cnt_n = cnt_dec;
            bit_n = crc[cnt_dec[2:0]];
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign Ready   = ready;
  assign TxBit   = tx_bit;
  assign TxValid = tx_valid;
  assign Done    = done;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Bench for crc_frame_tx: frame-level reference model for an 8-bit instance plus
// directed checks on a 16-bit instance; honours CRC_TX_PREAMBLE_EN.
module tb_crc_frame_tx;

`ifdef CRC_TX_PREAMBLE_EN
  localparam int PRE_LEN = 8;
`else
  localparam int PRE_LEN = 0;
`endif
  localparam logic [7:0] PRE_BYTE = 8'h7E;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Tick = 1'b0;
  logic        Start = 1'b0;
  logic        Start16 = 1'b0;
  logic [7:0]  Data8 = '0;
  logic [15:0] Data16 = '0;
  logic        Ready8, TxBit8, TxValid8, Done8;
  logic        Ready16, TxBit16, TxValid16, Done16;

  int checks = 0;
  int errors = 0;
  int dones8 = 0;
  logic [31:0] cap = '0;

  crc_frame_tx #(.DATA_W(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Data(Data8),
    .Ready(Ready8), .TxBit(TxBit8), .TxValid(TxValid8), .Done(Done8)
  );

  crc_frame_tx #(.DATA_W(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start16), .Data(Data16),
    .Ready(Ready16), .TxBit(TxBit16), .TxValid(TxValid16), .Done(Done16)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] crc8(input logic [31:0] d, input int w);
    logic [7:0] c;
    c = 8'h00;
    for (int i = w - 1; i >= 0; i--)
      c = {c[6:0], 1'b0} ^ (((d[i] ^ c[7]) == 1'b1) ? 8'h07 : 8'h00);
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the whole frame is laid out as a bit list at acceptance,
  // and each Tick simply advances the position in that list.
  logic       m_ready = 1'b1, m_valid = 1'b0, m_bit = 1'b0, m_done = 1'b0;
  int         m_idx = 0, m_len = 0;
  logic       mq [0:63];

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_bit <= 1'b0; m_done <= 1'b0; m_idx <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_ready) begin
        if (Start) begin
          int n;
          logic [7:0] c;
          n = 0;
          for (int i = PRE_LEN - 1; i >= 0; i--) begin mq[n] = PRE_BYTE[i]; n++; end
          for (int i = 7; i >= 0; i--) begin mq[n] = Data8[i]; n++; end
          c = crc8({24'h0, Data8}, 8);
          for (int i = 7; i >= 0; i--) begin mq[n] = c[i]; n++; end
          m_len   <= n;
          m_idx   <= 0;
          m_valid <= 1'b1;
          m_ready <= 1'b0;
          m_bit   <= mq[0];
        end
      end else if (Tick) begin
        if (m_idx + 1 == m_len) begin
          m_valid <= 1'b0; m_bit <= 1'b0; m_done <= 1'b1; m_ready <= 1'b1;
        end else begin
          m_bit <= mq[m_idx + 1];
        end
        m_idx <= m_idx + 1;
      end
    end
  end

  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      chk("ready8", {31'b0, Ready8}, {31'b0, m_ready});
      chk("txvalid8", {31'b0, TxValid8}, {31'b0, m_valid});
      chk("txbit8", {31'b0, TxBit8}, {31'b0, m_bit});
      chk("done8", {31'b0, Done8}, {31'b0, m_done});
      if (Done8) dones8++;
      if (Tick && TxValid8) cap <= {cap[30:0], TxBit8};
    end
  end

  task automatic step(input logic s, input logic t);
    @(posedge Clk);
    #1;
    Start = s;
    Tick  = t;
  endtask

  task automatic run8(input logic [7:0] d, input logic tick_hs, input logic mid);
    Data8 = d;
    step(1'b1, tick_hs);
    for (int n = 1; n <= 100; n++) begin
      step(mid && n == 10, (n % 4) == 0);
      if (mid && n == 10) Data8 = ~d;
    end
    step(1'b0, 1'b0);
  endtask

  localparam int FL8 = 16 + PRE_LEN;
  localparam logic [31:0] MASK8 = (32'h1 << FL8) - 32'h1;
  localparam logic [31:0] PRE_PART = (PRE_LEN != 0) ? 32'h007E_0000 : 32'h0;

  initial begin
    int d0, nt, n, tcount, len16;
    logic fin;
    Reset = 1'b1;
    #23;
    chk("rst_ready", {31'b0, Ready8}, 32'h1);
    chk("rst_txvalid", {31'b0, TxValid8}, 32'h0);
    chk("rst_txbit", {31'b0, TxBit8}, 32'h0);
    chk("rst_done", {31'b0, Done8}, 32'h0);
    @(posedge Clk); #1; Reset = 1'b0;
    step(1'b0, 1'b0);

    chk("model_crc_01", {24'h0, crc8(32'h01, 8)}, 32'h07);
    chk("model_crc_80", {24'h0, crc8(32'h80, 8)}, 32'h89);
    chk("model_crc_0000", {24'h0, crc8(32'h0, 16)}, 32'h00);

    d0 = dones8;
    run8(8'h01, 1'b0, 1'b0);
    chk("frame_01", cap & MASK8, PRE_PART | 32'h0107);
    chk("dones_01", dones8 - d0, 32'h1);

    d0 = dones8;
    run8(8'h80, 1'b1, 1'b1);
    chk("frame_80_ignored_start_tick", cap & MASK8, PRE_PART | 32'h8089);
    chk("dones_80", dones8 - d0, 32'h1);

    // 16-bit all-zero payload on the second instance.
    len16 = 24 + PRE_LEN;
    Data16 = '0;
    Start16 = 1'b1;
    step(1'b0, 1'b0);
    Start16 = 1'b0;
    tcount = 0;
    fin = 1'b0;
    for (int k = 1; k < 400 && !fin; k++) begin
      @(negedge Clk);
      if (tcount == len16) begin
        chk("z16_done", {31'b0, Done16}, 32'h1);
        chk("z16_ready", {31'b0, Ready16}, 32'h1);
        chk("z16_txvalid_end", {31'b0, TxValid16}, 32'h0);
        fin = 1'b1;
      end else begin
        chk("z16_txvalid", {31'b0, TxValid16}, 32'h1);
        chk("z16_txbit", {31'b0, TxBit16},
            (tcount < PRE_LEN) ? {31'b0, PRE_BYTE[7 - (tcount % 8)]} : 32'h0);
        if (Tick) tcount++;
      end
      if (!fin) step(1'b0, (k % 4) == 0);
    end
    chk("z16_finished_in_budget", {31'b0, fin}, 32'h1);

    // Asynchronous reset mid-frame after the 5th Tick.
    d0 = dones8;
    Data8 = 8'h3C;
    step(1'b1, 1'b0);
    nt = 0; n = 0;
    while (nt < 5) begin
      n++;
      step(1'b0, (n % 4) == 0);
      if ((n % 4) == 0) nt++;
    end
    step(1'b0, 1'b0);
    chk("pre_reset_txvalid", {31'b0, TxValid8}, 32'h1);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_ready", {31'b0, Ready8}, 32'h1);
    chk("async_txvalid", {31'b0, TxValid8}, 32'h0);
    chk("async_txbit", {31'b0, TxBit8}, 32'h0);
    chk("async_done", {31'b0, Done8}, 32'h0);
    @(posedge Clk); #1; Reset = 1'b0;
    for (int k = 1; k <= 20; k++) step(1'b0, (k % 4) == 0);
    chk("reset_no_done", dones8 - d0, 32'h0);
    run8(8'h01, 1'b0, 1'b0);
    chk("frame_after_reset", cap & MASK8, PRE_PART | 32'h0107);

    // Start held high: frames follow each other with one idle cycle between.
    d0 = dones8;
    Data8 = 8'hA5;
    for (int k = 1; k <= 150; k++) step(1'b1, (k % 4) == 0);
    for (int k = 1; k <= 110; k++) step(1'b0, (k % 4) == 0);
    chk("b2b_two_frames", {31'b0, (dones8 - d0) >= 2}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
